// File: rtl/free_list_pkg.sv
// Shared definitions for the rename free list.
//   PHY_REGS / ARC_REGS / DEPTH : register file sizing; DEPTH is the number of tags that
//                                 can be free at once.
//   phy_reg_t / arc_reg_t       : physical / architectural register tags.
//   ptr_add                     : mod-DEPTH pointer add; DEPTH need not be a power of two.
package free_list_pkg;

   localparam int unsigned PHY_REGS = 64;
   localparam int unsigned ARC_REGS = 32;
   localparam int unsigned DEPTH    = PHY_REGS - ARC_REGS;

   localparam int unsigned PHY_W = $clog2(PHY_REGS);
   localparam int unsigned ARC_W = $clog2(ARC_REGS);
   localparam int unsigned PTR_W = $clog2(DEPTH);
   localparam int unsigned CNT_W = $clog2(DEPTH + 1);

   typedef logic [PHY_W-1:0] phy_reg_t;
   typedef logic [ARC_W-1:0] arc_reg_t;
   typedef logic [PTR_W-1:0] ptr_t;
   typedef logic [PTR_W:0]   ptr_ext_t;
   typedef logic [CNT_W-1:0] cnt_t;
   // One extra bit so count - take + free never wraps before it is checked.
   typedef logic [CNT_W:0]   cnt_ext_t;

   // Both operands are below DEPTH, so a single compare-and-subtract wraps the sum.
   function automatic ptr_t ptr_add(input ptr_t base, input ptr_t inc);
      ptr_ext_t sum;
      sum = {1'b0, base} + {1'b0, inc};
      if (sum >= ptr_ext_t'(DEPTH)) begin
         sum = sum - ptr_ext_t'(DEPTH);
      end
      return sum[PTR_W-1:0];
   endfunction

endpackage

// File: rtl/free_list_fl_pack.sv
// fl_pack: combinational lane compactor.
// Moves the tags of the valid lanes down to a dense list (lane order preserved) and counts them.
//   lane_valid  in  LANES          lane i carries a real entry
//   lane_tag    in  LANES x TAG_W  tag per lane
//   pack_valid  out LANES          thermometer: first pack_count entries valid
//   pack_tag    out LANES x TAG_W  dense tag list, unused slots zero
//   pack_count  out                number of valid lanes
module fl_pack #(
   parameter int unsigned LANES = 3,
   parameter int unsigned TAG_W = 6,
   localparam int unsigned CW   = $clog2(LANES + 1)
) (
   input  logic [LANES-1:0]            lane_valid,
   input  logic [LANES-1:0][TAG_W-1:0] lane_tag,
   output logic [LANES-1:0]            pack_valid,
   output logic [LANES-1:0][TAG_W-1:0] pack_tag,
   output logic [CW-1:0]               pack_count
);

   always_comb begin
      pack_valid = '0;
      pack_tag   = '0;
      pack_count = '0;
      for (int i = 0; i < int'(LANES); i++) begin
         if (lane_valid[i]) begin
            // pack_count never exceeds i here, so the slot index stays in range.
            pack_tag[pack_count]   = lane_tag[i];
            pack_valid[pack_count] = 1'b1;
            pack_count             = pack_count + CW'(1);
         end
      end
   end

endmodule

// File: rtl/free_list.sv
// free_list: physical-register free list for the rename stage.
// Circular buffer of free tags. Rename takes the oldest tags (head), retire returns displaced
// tags at the tail, and a committed head (chead) lets a flush restore the committed free set
// in one cycle.
//   clk, rst_n       clock, asynchronous active-low reset
//   ret_valid        retire lane commits this cycle
//   ret_phy_dst_old  tag displaced by the committing instruction (0 = none)
//   alloc_avail      bit i set when more than i tags are free
//   alloc_preg       lane i shows the (i+1)-th oldest free tag
//   alloc_take       rename consumes lanes, prefix-packed from lane 0
//   flush            mispredict/exception recovery
//   free_count       registered occupancy
module free_list
   import free_list_pkg::*;
#(
   parameter int unsigned RET_WIDTH   = 3,
   parameter int unsigned ALLOC_WIDTH = 3
) (
   input  logic                             clk,
   input  logic                             rst_n,
   input  logic     [RET_WIDTH-1:0]         ret_valid,
   input  phy_reg_t [RET_WIDTH-1:0]         ret_phy_dst_old,
   output logic     [ALLOC_WIDTH-1:0]       alloc_avail,
   output phy_reg_t [ALLOC_WIDTH-1:0]       alloc_preg,
   input  logic     [ALLOC_WIDTH-1:0]       alloc_take,
   input  logic                             flush,
   output logic     [CNT_W-1:0]             free_count
);

   localparam int unsigned NF_W = $clog2(RET_WIDTH + 1);
   localparam int unsigned NT_W = $clog2(ALLOC_WIDTH + 1);

   phy_reg_t slot_q [DEPTH];
   ptr_t     head_q, head_d;
   ptr_t     tail_q, tail_d;
   ptr_t     chead_q, chead_d;
   cnt_t     count_q, count_d;

   logic     [RET_WIDTH-1:0]         free_lane;
   logic     [RET_WIDTH-1:0]         pack_valid;
   phy_reg_t [RET_WIDTH-1:0]         pack_tag;
   logic     [NF_W-1:0]              nfree;
   logic     [ALLOC_WIDTH-1:0]       take_eff;
   logic     [NT_W-1:0]              ntake;
   ptr_t                             head_take;
   cnt_ext_t                         count_sum;

   // A zero tag means the instruction displaced nothing.
   always_comb begin
      free_lane = '0;
      for (int i = 0; i < int'(RET_WIDTH); i++) begin
         free_lane[i] = ret_valid[i] && (ret_phy_dst_old[i] != '0);
      end
   end

   fl_pack #(
      .LANES (RET_WIDTH),
      .TAG_W (PHY_W)
   ) u_fl_pack (
      .lane_valid (free_lane),
      .lane_tag   (ret_phy_dst_old),
      .pack_valid (pack_valid),
      .pack_tag   (pack_tag),
      .pack_count (nfree)
   );

   // Outputs depend on registered state only; frees show up the following cycle.
   always_comb begin
      alloc_avail = '0;
      alloc_preg  = '0;
      for (int i = 0; i < int'(ALLOC_WIDTH); i++) begin
         alloc_avail[i] = count_q > cnt_t'(i);
         alloc_preg[i]  = slot_q[ptr_add(head_q, ptr_t'(i))];
      end
   end

   assign free_count = count_q;

   always_comb begin
      take_eff = alloc_take & alloc_avail;
      ntake    = '0;
      for (int i = 0; i < int'(ALLOC_WIDTH); i++) begin
         if (take_eff[i]) begin
            ntake = ntake + NT_W'(1);
         end
      end
   end

   always_comb begin
      head_take = ptr_add(head_q, ptr_t'(ntake));
      tail_d    = ptr_add(tail_q, ptr_t'(nfree));
      chead_d   = ptr_add(chead_q, ptr_t'(nfree));
      count_sum = cnt_ext_t'(count_q) - cnt_ext_t'(ntake) + cnt_ext_t'(nfree);
      if (flush) begin
         // Rewind to the committed head, including this cycle's commits; takes are dropped.
         head_d  = chead_d;
         count_d = cnt_t'(DEPTH);
      end else begin
         head_d  = head_take;
         count_d = count_sum[CNT_W-1:0];
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < int'(DEPTH); i++) begin
            slot_q[i] <= phy_reg_t'(ARC_REGS + i);
         end
         head_q  <= '0;
         tail_q  <= '0;
         chead_q <= '0;
         count_q <= cnt_t'(DEPTH);
      end else begin
         for (int j = 0; j < int'(RET_WIDTH); j++) begin
            if (pack_valid[j]) begin
               slot_q[ptr_add(tail_q, ptr_t'(j))] <= pack_tag[j];
            end
         end
         head_q  <= head_d;
         tail_q  <= tail_d;
         chead_q <= chead_d;
         count_q <= count_d;
      end
   end

`ifndef SYNTHESIS
   // Set once the allocation pointer has gone all the way round the buffer.
   logic wrapped_q;
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wrapped_q <= 1'b0;
      end else if (!flush && (ntake != '0) && (head_take < head_q)) begin
         wrapped_q <= 1'b1;
      end
   end

   a_take_prefix: assert property (@(posedge clk) disable iff (!rst_n)
      (alloc_take & (alloc_take + 1'b1)) == '0);

   a_take_avail: assert property (@(posedge clk) disable iff (!rst_n)
      !flush |-> ((alloc_take & ~alloc_avail) == '0));

   a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
      !flush |-> (count_sum <= cnt_ext_t'(DEPTH)));

   for (genvar g = 0; g < int'(RET_WIDTH); g++) begin : g_free_chk
      a_arch_free: assert property (@(posedge clk) disable iff (!rst_n)
         (free_lane[g] && !wrapped_q) |-> (ret_phy_dst_old[g] >= phy_reg_t'(ARC_REGS)));
   end
`endif

endmodule

// File: tb/tb_free_list.sv
// Self-checking bench for free_list: an ordered-queue model of the free set plus directed
// vectors with hand-computed expectations.
module tb_free_list;
   import free_list_pkg::*;

   localparam int AW = 3;
   localparam int RW = 3;

   logic              clk   = 1'b0;
   logic              rst_n = 1'b0;
   logic [RW-1:0]     ret_valid = '0;
   phy_reg_t [RW-1:0] ret_phy_dst_old = '0;
   logic [AW-1:0]     alloc_avail;
   phy_reg_t [AW-1:0] alloc_preg;
   logic [AW-1:0]     alloc_take = '0;
   logic              flush = 1'b0;
   logic [CNT_W-1:0]  free_count;

   int n_chk  = 0;
   int n_fail = 0;
   bit cmp_en = 1'b0;

   // fq: free tags in hand-out order. hist: reset image followed by every freed tag in order;
   // the committed free set is always the DEPTH entries of hist starting at n_freed.
   int fq[$];
   int hist[$];
   int n_freed;

   always #5 clk = ~clk;

   free_list dut (
      .clk             (clk),
      .rst_n           (rst_n),
      .ret_valid       (ret_valid),
      .ret_phy_dst_old (ret_phy_dst_old),
      .alloc_avail     (alloc_avail),
      .alloc_preg      (alloc_preg),
      .alloc_take      (alloc_take),
      .flush           (flush),
      .free_count      (free_count)
   );

   task automatic chk(input string name, input int act, input int exp);
      n_chk++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      fq.delete();
      hist.delete();
      n_freed = 0;
      for (int i = 0; i < int'(DEPTH); i++) begin
         fq.push_back(int'(ARC_REGS) + i);
         hist.push_back(int'(ARC_REGS) + i);
      end
   endtask

   // Drive one cycle of stimulus, advance the model at the clock edge, return at the negedge.
   task automatic step(input logic [AW-1:0] take, input logic [RW-1:0] rv,
                       input int t0, input int t1, input int t2, input bit fl);
      int tags[3];
      tags = '{t0, t1, t2};
      alloc_take = take;
      ret_valid  = rv;
      flush      = fl;
      for (int i = 0; i < RW; i++) ret_phy_dst_old[i] = phy_reg_t'(tags[i]);
      @(posedge clk);
      if (!fl) begin
         for (int i = 0; i < AW; i++) begin
            if (take[i] && fq.size() > 0) void'(fq.pop_front());
         end
      end
      for (int i = 0; i < RW; i++) begin
         if (rv[i] && tags[i] != 0) begin
            hist.push_back(tags[i]);
            n_freed++;
            if (!fl) fq.push_back(tags[i]);
         end
      end
      if (fl) begin
         fq.delete();
         for (int k = 0; k < int'(DEPTH); k++) fq.push_back(hist[n_freed + k]);
      end
      @(negedge clk);
      alloc_take      = '0;
      ret_valid       = '0;
      flush           = 1'b0;
      ret_phy_dst_old = '0;
   endtask

   task automatic check_reset_image(input string tag);
      chk({tag, "_count"}, int'(free_count), 32);
      chk({tag, "_avail"}, int'(alloc_avail), 7);
      chk({tag, "_preg0"}, int'(alloc_preg[0]), 32);
      chk({tag, "_preg1"}, int'(alloc_preg[1]), 33);
      chk({tag, "_preg2"}, int'(alloc_preg[2]), 34);
   endtask

   // Asynchronous reset pulse between clock edges; outputs are checked before any edge.
   task automatic pulse_reset(input string tag);
      #2 rst_n = 1'b0;
      #1 model_reset();
      check_reset_image(tag);
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   // Compare process: DUT against the model on every negedge.
   initial begin
      forever begin
         @(negedge clk);
         if (cmp_en) begin
            chk("model_count", int'(free_count), fq.size());
            for (int i = 0; i < AW; i++) begin
               chk($sformatf("model_avail%0d", i), int'(alloc_avail[i]), (fq.size() > i) ? 1 : 0);
               if (fq.size() > i) begin
                  chk($sformatf("model_preg%0d", i), int'(alloc_preg[i]), fq[i]);
               end
            end
         end
      end
   end

   initial begin
      model_reset();
      @(negedge clk);
      rst_n = 1'b1;
      #1 check_reset_image("reset");
      cmp_en = 1'b1;
      @(negedge clk);

      // Hand out 30 tags in order.
      for (int k = 0; k < 10; k++) begin
         chk("issue_order", int'(alloc_preg[0]), 32 + 3 * k);
         step(3'b111, 3'b000, 0, 0, 0, 1'b0);
      end
      chk("after30_count", int'(free_count), 2);
      chk("after30_avail", int'(alloc_avail), 3);
      chk("after30_preg0", int'(alloc_preg[0]), 62);
      chk("after30_preg1", int'(alloc_preg[1]), 63);

      // Drain, then free 5 and 7 on lanes 0 and 2.
      step(3'b011, 3'b000, 0, 0, 0, 1'b0);
      chk("empty_count", int'(free_count), 0);
      chk("empty_avail", int'(alloc_avail), 0);
      step(3'b000, 3'b101, 5, 9, 7, 1'b0);
      chk("refill_count", int'(free_count), 2);
      chk("refill_avail", int'(alloc_avail), 3);
      chk("refill_preg0", int'(alloc_preg[0]), 5);
      chk("refill_preg1", int'(alloc_preg[1]), 7);

      // Take two while freeing two: old tags still shown in the take cycle.
      alloc_take         = 3'b011;
      ret_valid          = 3'b011;
      ret_phy_dst_old[0] = phy_reg_t'(9);
      ret_phy_dst_old[1] = phy_reg_t'(11);
      #1 chk("nobypass_preg0", int'(alloc_preg[0]), 5);
      chk("nobypass_count", int'(free_count), 2);
      step(3'b011, 3'b011, 9, 11, 0, 1'b0);
      chk("swap_count", int'(free_count), 2);
      chk("swap_preg0", int'(alloc_preg[0]), 9);
      chk("swap_preg1", int'(alloc_preg[1]), 11);

      // Flush after 5 takes; the flush cycle retires one real tag and one zero tag.
      pulse_reset("reset2");
      step(3'b111, 3'b000, 0, 0, 0, 1'b0);
      step(3'b011, 3'b000, 0, 0, 0, 1'b0);
      chk("pre_flush_count", int'(free_count), 27);
      step(3'b001, 3'b011, 40, 0, 0, 1'b1);
      chk("flush_count", int'(free_count), 32);
      chk("flush_avail", int'(alloc_avail), 7);
      chk("flush_preg0", int'(alloc_preg[0]), 33);
      chk("flush_preg1", int'(alloc_preg[1]), 34);
      repeat (10) step(3'b111, 3'b000, 0, 0, 0, 1'b0);
      chk("tailwrite_preg0", int'(alloc_preg[0]), 63);
      chk("tailwrite_preg1", int'(alloc_preg[1]), 40);

      // Valid lanes with zero tags free nothing.
      step(3'b000, 3'b111, 0, 0, 0, 1'b0);
      chk("zero_tag_count", int'(free_count), 2);

      // Wrap the head, free a few, then reset mid-stream.
      step(3'b001, 3'b000, 0, 0, 0, 1'b0);
      chk("wrap_count", int'(free_count), 1);
      step(3'b000, 3'b111, 50, 51, 52, 1'b0);
      chk("wrap_free_count", int'(free_count), 4);
      chk("wrap_free_preg0", int'(alloc_preg[0]), 40);
      chk("wrap_free_preg1", int'(alloc_preg[1]), 50);
      pulse_reset("midreset");
      step(3'b000, 3'b000, 0, 0, 0, 1'b0);
      chk("post_reset_count", int'(free_count), 32);

      cmp_en = 1'b0;
      #1;
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/free_list.md
Name: free_list

Overview:
- Physical-register free list for the rename stage.
- Circular buffer of free physical register tags.
- Hands the oldest free tags to rename for allocation.
- Takes back the displaced tags (phy_dst_old) from the retire bundle as instructions commit.
- Tracks a committed head pointer so a pipeline flush restores the architecturally correct free set in one cycle.

Parameters:
- PHY_REGS, 64, number of physical registers; phy_reg_t is $clog2(PHY_REGS) bits.
- ARC_REGS, 32, number of architectural registers; DEPTH = PHY_REGS - ARC_REGS.
- RET_WIDTH, 3, retire lanes consumed per cycle; matches the retire bundle width.
- ALLOC_WIDTH, 3, rename allocation lanes per cycle.

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- ret_valid  in  RET_WIDTH  retire lane i commits this cycle.
- ret_phy_dst_old  in  RET_WIDTH x phy_reg_t  tag displaced by the committing instruction; 0 means none.
- alloc_avail  out  ALLOC_WIDTH  bit i set when count > i.
- alloc_preg  out  ALLOC_WIDTH x phy_reg_t  lane i shows buf[(head+i) mod DEPTH].
- alloc_take  in  ALLOC_WIDTH  rename consumes lane i; must be prefix-packed (lane 0 upward).
- flush  in  1  mispredict/exception recovery.
- free_count  out  $clog2(DEPTH+1)  registered occupancy.

Behaviour:
- Interface decision: one clock (clk); reset is asynchronous and active-low (rst_n).
- All state is in flops: buf[DEPTH], head, tail, chead (committed head), count.
- Reset (async, rst_n low):
  - buf[i] = ARC_REGS + i; head = chead = tail = 0; count = DEPTH.
  - Consequence: alloc_avail = all ones, alloc_preg = ARC_REGS..ARC_REGS+ALLOC_WIDTH-1.
- Reset mid-operation discards every pointer and restores the reset image.
- Frees:
  - Lane i frees when ret_valid[i] && ret_phy_dst_old[i] != 0.
  - Freeing lanes are written at tail, tail+1, ... in lane order, skipping non-freeing lanes (packing).
  - tail advances by nfree mod DEPTH.
  - chead advances by nfree mod DEPTH. Every committing allocator displaces exactly one nonzero tag; p0 is never allocated or freed.
- Allocation:
  - ntake = popcount(alloc_take); head advances by ntake mod DEPTH.
  - Outputs are combinational from registered head/count only. No same-cycle bypass of frees into alloc_avail or alloc_preg; freed tags become visible the next cycle.
  - ntake is applied only if alloc_take[i] implies alloc_avail[i].
- Count:
  - Next count = count - ntake + nfree, no flush.
  - Arithmetic is in $clog2(DEPTH+1)+1 bits.
- Flush:
  - head = chead + nfree (this cycle's retire still frees and commits).
  - count = DEPTH; alloc_take that cycle is ignored; tail updates normally.
  - Next cycle alloc_preg[0] = tag at the post-flush committed head.
- Wrap-around: all pointer arithmetic is mod DEPTH. DEPTH need not be a power of two; use a compare-and-subtract helper.
- Error conditions (simulation assertions; RTL behaviour undefined):
  - Non-prefix-packed alloc_take.
  - alloc_take[i] without alloc_avail[i].
  - count - ntake + nfree > DEPTH.
  - ret_phy_dst_old freeing a tag < ARC_REGS before any allocation has wrapped.
- Latency: a free is visible to rename 1 cycle after retire; an allocation is 0-cycle (same-cycle take).

Decomposition:
- Shared package (defs): phy_reg_t, arc_reg_t, PHY_REGS, ARC_REGS, DEPTH, and the mod-DEPTH add function for pointer wrap.
- One natural sub-module: fl_pack. It is combinational and compacts the RET_WIDTH free lanes into a dense write list plus count nfree. It is reusable for the store-queue retire side.
- The rest lives in free_list.

Test Plan:
- Reset, no stimulus -> free_count=32, alloc_avail=3'b111, alloc_preg={32,33,34}.
- alloc_take=3'b111 for 10 cycles -> pregs 32..61 handed out in order; then free_count=2, alloc_avail=3'b011, alloc_preg[0..1]={62,63}.
- Drain to 0, then ret_valid=3'b101 with phy_dst_old {5,x,7} -> next cycle free_count=2, alloc_preg[0]=5, alloc_preg[1]=7, alloc_avail=3'b011.
- Same cycle at count=2: alloc_take=3'b011 plus two frees {9,11} -> free_count stays 2; alloc_preg next cycle={9,11}; no bypass in the take cycle.
- Flush after 5 takes and 2 retires (one with phy_dst_old=0) -> free_count=32; alloc_preg[0]=tag at chead, i.e. the 2nd tag issued after reset (33); that cycle's retire free is still written at tail.
- Assert rst_n low mid-stream with pointers wrapped -> outputs return to reset image asynchronously; phy_dst_old=0 on a valid lane never increments free_count.
